rf_write_arbiter: RTL and testbench

- Shares the register file's single write port among 4 requesters: ALU writeback, load unit, branch-link, and a debug/CSR port.
- Performs round-robin arbitration and registers the winner's address and data.
- Drives the write port: wr_en feeds the 3-to-8 write decoder's enable, wr_addr feeds its select, wr_data feeds the register inputs.
- At most one register write per clock.

---
 rtl/rf_write_arbiter.sv | 93 +++++++++
 tb/tb_rf_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: four requesters (ALU writeback, load unit,
// branch-link, debug/CSR) share one write port through round-robin arbitration.
// The winner's address and data are registered and drive the write decoder.
// Optional build macro: RF_ZERO_REG_PROTECT_EN -- when defined, a winning
// request to address 0 is granted but does not assert wr_en.
module rf_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            gnt,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  busy
);

    logic [1:0]        ptr_p1;
    logic [3:0]        gnt_p1;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic              busy_p1;

    logic [3:0]        elig_p0;
    logic              found_p0;
    logic [1:0]        win_p0;
    logic [1:0]        idx_p0;
    logic [3:0]        win_oh_p0;
    logic [3:0]        rem_p0;
    logic [ADDR_W-1:0] win_addr_p0;
    logic [DATA_W-1:0] win_data_p0;
    logic              wr_ok_p0;

    // Stage p0: mask the currently granted requester and pick the first
    // eligible one starting at the round-robin pointer.
    always_comb begin
        elig_p0  = req & ~gnt_p1;
        found_p0 = 1'b0;
        win_p0   = ptr_p1;
        idx_p0   = ptr_p1;
        // Scan from the farthest offset down so the nearest eligible wins.
        for (int i = 3; i >= 0; i--) begin
            idx_p0 = ptr_p1 + i[1:0];
            if (elig_p0[idx_p0]) begin
                found_p0 = 1'b1;
                win_p0   = idx_p0;
            end
        end
        win_oh_p0   = found_p0 ? (4'b0001 << win_p0) : 4'b0000;
        rem_p0      = req & ~win_oh_p0;
        win_addr_p0 = req_addr[win_p0*ADDR_W +: ADDR_W];
        win_data_p0 = req_data[win_p0*DATA_W +: DATA_W];
`ifdef RF_ZERO_REG_PROTECT_EN
        // Register 0 is hard-wired zero: grant the request but suppress the write.
        wr_ok_p0 = found_p0 && (win_addr_p0 != '0);
`else
        wr_ok_p0 = found_p0;
`endif
    end

    // Stage p1: register the grant, write command and pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_p1   <= 2'd0;
            gnt_p1   <= 4'b0000;
            wr_en_p1 <= 1'b0;
            addr_p1  <= '0;
            data_p1  <= '0;
            busy_p1  <= 1'b0;
        end else begin
            gnt_p1   <= win_oh_p0;
            wr_en_p1 <= wr_ok_p0;
            busy_p1  <= |rem_p0;
            if (found_p0) begin
                ptr_p1  <= win_p0 + 2'd1;
                addr_p1 <= win_addr_p0;
                data_p1 <= win_data_p0;
            end
        end
    end

    assign gnt     = gnt_p1;
    assign wr_en   = wr_en_p1;
    assign wr_addr = addr_p1;
    assign wr_data = data_p1;
    assign busy    = busy_p1;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A behavioural model predicts the
// registered outputs for every driven cycle and pushes them to a scoreboard
// queue; each test pops and compares after the clock edge.
module tb_rf_write_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int OW     = 4 + 1 + ADDR_W + DATA_W + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [3:0]          req;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          gnt;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [OW-1:0] sb[$];
    logic [OW-1:0] exp_v;
    logic [OW-1:0] got_v;

    // model state
    int                m_ptr;
    logic [3:0]        m_gnt;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_busy;

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, predict the post-edge outputs, advance.
    task automatic cycle(input logic r, input logic [3:0] rq,
                         input logic [4*ADDR_W-1:0] ad, input logic [4*DATA_W-1:0] dt);
        logic [3:0] elig;
        int w;
        reset = r; req = rq; req_addr = ad; req_data = dt;
        if (r) begin
            m_ptr = 0; m_gnt = 0; m_we = 0; m_addr = 0; m_data = 0; m_busy = 0;
        end else begin
            elig = rq & ~m_gnt;
            w = -1;
            for (int i = 0; i < 4; i++)
                if (w < 0 && elig[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
            if (w >= 0) begin
                m_gnt  = 4'(1 << w);
                m_addr = ad[w*ADDR_W +: ADDR_W];
                m_data = dt[w*DATA_W +: DATA_W];
                m_we   = 1'b1;
`ifdef RF_ZERO_REG_PROTECT_EN
                if (m_addr == 0) m_we = 1'b0;
`endif
                m_ptr  = (w + 1) % 4;
                m_busy = |(rq & ~m_gnt);
            end else begin
                m_gnt  = 0;
                m_we   = 0;
                m_busy = |rq;
            end
        end
        sb.push_back({m_gnt, m_we, m_addr, m_data, m_busy});
        @(posedge clk);
        #1;
        got_v = {gnt, wr_en, wr_addr, wr_data, busy};
    endtask

    function automatic logic [4*ADDR_W-1:0] std_addr();
        return {3'd4, 3'd3, 3'd2, 3'd1};
    endfunction
    function automatic logic [4*DATA_W-1:0] std_data();
        return {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 4'b1111, std_addr(), std_data());
            exp_v = sb.pop_front();
            n_tests++;
            if (got_v !== exp_v || got_v !== '0) begin
                n_fail++;
                $display("FAIL reset cyc%0d got %h required %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_single();
        logic [4*ADDR_W-1:0] ad;
        logic [4*DATA_W-1:0] dt;
        ad = std_addr(); dt = std_data();
        ad[2*ADDR_W +: ADDR_W] = 3'd5;
        dt[2*DATA_W +: DATA_W] = 16'hBEEF;
        cycle(1'b0, 4'b0100, ad, dt);
        exp_v = sb.pop_front();
        n_tests++;
        if (got_v !== exp_v || gnt !== 4'b0100 || wr_en !== 1'b1 ||
            wr_addr !== 3'd5 || wr_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL single_grant got %h required %h", got_v, exp_v);
        end
        cycle(1'b0, 4'b0000, ad, dt);
        exp_v = sb.pop_front();
        n_tests++;
        if (got_v !== exp_v || gnt !== 4'b0000 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release got %h required %h", got_v, exp_v);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
        cycle(1'b1, 4'b0000, std_addr(), std_data());
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b1111, std_addr(), std_data());
            exp_v = sb.pop_front();
            n_tests++;
            if (got_v !== exp_v || gnt !== seq[i] || wr_en !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL round_robin cyc%0d got %h required %h gnt %b", i, got_v, exp_v, seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 4'b0000, std_addr(), std_data());
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'b0010, std_addr(), std_data());
            exp_v = sb.pop_front();
            n_tests++;
            if (got_v !== exp_v || gnt[1] !== ((i % 2) == 0) || wr_en !== gnt[1]) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d got %h required %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_ptr_gap();
        logic [3:0] rq  [3] = '{4'b0100, 4'b0101, 4'b0101};
        logic [3:0] seq [3] = '{4'b0100, 4'b0001, 4'b0100};
        cycle(1'b1, 4'b0000, std_addr(), std_data());
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, rq[i], std_addr(), std_data());
            exp_v = sb.pop_front();
            n_tests++;
            if (got_v !== exp_v || gnt !== seq[i]) begin
                n_fail++;
                $display("FAIL ptr_gap cyc%0d got %h required %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic       rs  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0000, 4'b0001};
        cycle(1'b1, 4'b0000, std_addr(), std_data());
        void'(sb.pop_front());
        // advance the pointer off zero first so the reset has something to clear
        for (int i = 0; i < 4; i++) begin
            cycle(rs[i], 4'b0011, std_addr(), std_data());
            exp_v = sb.pop_front();
            n_tests++;
            if (got_v !== exp_v || gnt !== seq[i] || (rs[i] && got_v !== '0)) begin
                n_fail++;
                $display("FAIL mid_reset cyc%0d got %h required %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [4*ADDR_W-1:0] ad;
        logic [4*DATA_W-1:0] dt;
        logic                we_req;
`ifdef RF_ZERO_REG_PROTECT_EN
        we_req = 1'b0;
`else
        we_req = 1'b1;
`endif
        ad = std_addr(); dt = std_data();
        ad[3*ADDR_W +: ADDR_W] = 3'd0;
        dt[3*DATA_W +: DATA_W] = 16'h1234;
        cycle(1'b1, 4'b0000, ad, dt);
        void'(sb.pop_front());
        cycle(1'b0, 4'b1000, ad, dt);
        exp_v = sb.pop_front();
        n_tests++;
        if (got_v !== exp_v || gnt !== 4'b1000 || wr_en !== we_req) begin
            n_fail++;
            $display("FAIL zero_reg got %h required %h", got_v, exp_v);
        end
    endtask

    task automatic test_random();
        logic [4*ADDR_W-1:0] ad;
        logic [4*DATA_W-1:0] dt;
        logic                r;
        for (int i = 0; i < 300; i++) begin
            ad = {$urandom, $urandom};
            dt = {$urandom, $urandom};
            r  = ($urandom_range(0, 40) == 0);
            cycle(r, 4'($urandom), ad, dt);
            exp_v = sb.pop_front();
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc%0d got %h required %h", i, got_v, exp_v);
            end
            n_tests++;
            if (!$onehot0(gnt) || (wr_en && !$onehot(gnt))) begin
                n_fail++;
                $display("FAIL onehot cyc%0d gnt %b wr_en %b required one-hot", i, gnt, wr_en);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_ptr_gap();
        test_mid_reset();
        test_zero_reg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
